// File: rtl/controle_multiciclo_if.sv
// Bus between the multicycle controller and the RISC-V datapath.
//
// Purpose: groups the instruction/status inputs and the control outputs
// that travel between the controller and the datapath.
//
// Signals:
//   instrucao    32  instruction word latched by the fetch stage
//   pc           32  current PC (word index)
//   zero          1  ALU zero flag
//   estado        4  current controller state
//   pc_escreve    1  PC load strobe
//   pc_fonte      1  0 = PC+1, 1 = PC+branch offset
//   reg_escreve   1  register file write enable
//   mem_le        1  data memory read enable
//   mem_escreve   1  data memory write enable
//   mem_para_reg  1  write-back source (0 = ALU, 1 = memory)
//   alu_src       1  ALU B operand (0 = rs2, 1 = immediate)
//   alu_op        2  00 add, 01 sub, 10 decode funct3/funct7
//   parado        1  halted flag
//   ciclos       32  cycle counter        (only with PERF_CNT_EN)
//   instr_exec   32  retired instructions (only with PERF_CNT_EN)
//
// Modports: master = controller, slave = datapath.
// Optional macro: PERF_CNT_EN adds the performance counter signals.

interface controle_multiciclo_if;
  logic [31:0] instrucao;
  logic [31:0] pc;
  logic        zero;
  logic [3:0]  estado;
  logic        pc_escreve;
  logic        pc_fonte;
  logic        reg_escreve;
  logic        mem_le;
  logic        mem_escreve;
  logic        mem_para_reg;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        parado;
`ifdef PERF_CNT_EN
  logic [31:0] ciclos;
  logic [31:0] instr_exec;
`endif

`ifdef PERF_CNT_EN
  modport master (
    input  instrucao, pc, zero,
    output estado, pc_escreve, pc_fonte, reg_escreve, mem_le, mem_escreve,
           mem_para_reg, alu_src, alu_op, parado, ciclos, instr_exec
  );

  modport slave (
    output instrucao, pc, zero,
    input  estado, pc_escreve, pc_fonte, reg_escreve, mem_le, mem_escreve,
           mem_para_reg, alu_src, alu_op, parado, ciclos, instr_exec
  );
`else
  modport master (
    input  instrucao, pc, zero,
    output estado, pc_escreve, pc_fonte, reg_escreve, mem_le, mem_escreve,
           mem_para_reg, alu_src, alu_op, parado
  );

  modport slave (
    output instrucao, pc, zero,
    input  estado, pc_escreve, pc_fonte, reg_escreve, mem_le, mem_escreve,
           mem_para_reg, alu_src, alu_op, parado
  );
`endif
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RISC-V datapath.
//
// Purpose: sequences each fetched instruction through decode, execute,
// memory and write-back states and emits the per-state control strobes.
// Halts permanently (until reset) on an illegal/all-zero instruction, on a
// corrupted state encoding, or when PC leaves program memory.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   bus    master modport of controle_multiciclo_if (instruction, pc, zero
//          in; estado and all control strobes out)
//
// Parameters:
//   NUM_INSTR  number of instruction memory words; valid PC is 0..NUM_INSTR-1
//
// Optional macro: PERF_CNT_EN adds the ciclos / instr_exec counters.

module controle_multiciclo #(
  parameter int NUM_INSTR = 18
) (
  input logic                  clk,
  input logic                  reset,
  controle_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    BUSCA       = 4'b0000,
    DECODIFICA  = 4'b0001,
    EXEC_R      = 4'b0010,
    EXEC_I      = 4'b0011,
    CALC_END    = 4'b0100,
    LER_MEM     = 4'b0101,
    ESCREVE_MEM = 4'b0110,
    ESCRITA_REG = 4'b0111,
    DESVIO      = 4'b1000,
    FIM         = 4'b1001
  } state_t;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] PC_LIMIT  = 32'(NUM_INSTR);

  state_t      state;
  state_t      state_next;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch_taken;

  logic        pc_escreve;
  logic        pc_fonte;
  logic        reg_escreve;
  logic        mem_le;
  logic        mem_escreve;
  logic        mem_para_reg;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        parado;

  // Only opcode and funct3 steer the controller; the remaining fields belong
  // to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instrucao[31:15], bus.instrucao[11:7]};

  assign opcode = bus.instrucao[6:0];
  assign funct3 = bus.instrucao[14:12];

  // beq takes on zero, bne on non-zero; other funct3 codes fall through.
  assign branch_taken = ((funct3 == 3'b000) &&  bus.zero) ||
                        ((funct3 == 3'b001) && !bus.zero);

  always_ff @(posedge clk) begin
    if (reset) state <= BUSCA;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = FIM;
    pc_escreve   = 1'b0;
    pc_fonte     = 1'b0;
    reg_escreve  = 1'b0;
    mem_le       = 1'b0;
    mem_escreve  = 1'b0;
    mem_para_reg = 1'b0;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    parado       = 1'b0;

    case (state)
      BUSCA: begin
        state_next = (bus.pc >= PC_LIMIT) ? FIM : DECODIFICA;
      end

      DECODIFICA: begin
        case (opcode)
          OP_R:               state_next = EXEC_R;
          OP_I:               state_next = EXEC_I;
          OP_LOAD, OP_STORE:  state_next = CALC_END;
          OP_BRANCH:          state_next = DESVIO;
          default:            state_next = FIM;
        endcase
      end

      EXEC_R: begin
        alu_op     = 2'b10;
        state_next = ESCRITA_REG;
      end

      EXEC_I: begin
        alu_op     = 2'b10;
        alu_src    = 1'b1;
        state_next = ESCRITA_REG;
      end

      CALC_END: begin
        alu_src    = 1'b1;
        state_next = (opcode == OP_LOAD) ? LER_MEM : ESCREVE_MEM;
      end

      LER_MEM: begin
        mem_le     = 1'b1;
        alu_src    = 1'b1;
        state_next = ESCRITA_REG;
      end

      // Stores have no write-back, so the PC is advanced here.
      ESCREVE_MEM: begin
        mem_escreve = 1'b1;
        alu_src     = 1'b1;
        pc_escreve  = 1'b1;
        state_next  = BUSCA;
      end

      ESCRITA_REG: begin
        reg_escreve  = 1'b1;
        pc_escreve   = 1'b1;
        mem_para_reg = (opcode == OP_LOAD);
        state_next   = BUSCA;
      end

      DESVIO: begin
        alu_op     = 2'b01;
        pc_escreve = 1'b1;
        pc_fonte   = branch_taken;
        state_next = BUSCA;
      end

      FIM: begin
        parado     = 1'b1;
        state_next = FIM;
      end

      // Unused encodings are treated as a fault and halt the core.
      default: begin
        state_next = FIM;
      end
    endcase
  end

  assign bus.estado       = state;
  assign bus.pc_escreve   = pc_escreve;
  assign bus.pc_fonte     = pc_fonte;
  assign bus.reg_escreve  = reg_escreve;
  assign bus.mem_le       = mem_le;
  assign bus.mem_escreve  = mem_escreve;
  assign bus.mem_para_reg = mem_para_reg;
  assign bus.alu_src      = alu_src;
  assign bus.alu_op       = alu_op;
  assign bus.parado       = parado;

`ifdef PERF_CNT_EN
  logic [31:0] ciclos;
  logic [31:0] instr_exec;

  // Both counters freeze once halted; pc_escreve is never high in FIM.
  always_ff @(posedge clk) begin
    if (reset) begin
      ciclos     <= 32'd0;
      instr_exec <= 32'd0;
    end else begin
      if (state != FIM) ciclos     <= ciclos + 32'd1;
      if (pc_escreve)   instr_exec <= instr_exec + 32'd1;
    end
  end

  assign bus.ciclos     = ciclos;
  assign bus.instr_exec = instr_exec;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo.
//
// Purpose: drives directed and randomized instructions and compares every
// cycle of the controller against a reference model that derives the state
// path from the instruction class and the strobes from the position of each
// cycle within that path.
//
// Ports: none (top-level bench). Optional macro PERF_CNT_EN enables the
// performance counter checks.

module tb_controle_multiciclo;

  localparam int NUM_INSTR = 18;

  localparam int C_R      = 0;
  localparam int C_I      = 1;
  localparam int C_LOAD   = 2;
  localparam int C_STORE  = 3;
  localparam int C_BRANCH = 4;
  localparam int C_ILL    = 5;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcf;
    logic       regw;
    logic       meml;
    logic       memw;
    logic       m2r;
    logic       asrc;
    logic [1:0] aop;
    logic       par;
  } obs_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  controle_multiciclo_if bus ();

  controle_multiciclo #(.NUM_INSTR(NUM_INSTR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.st   = bus.estado;
    o.pcw  = bus.pc_escreve;
    o.pcf  = bus.pc_fonte;
    o.regw = bus.reg_escreve;
    o.meml = bus.mem_le;
    o.memw = bus.mem_escreve;
    o.m2r  = bus.mem_para_reg;
    o.asrc = bus.alu_src;
    o.aop  = bus.alu_op;
    o.par  = bus.parado;
    return o;
  endfunction

  function automatic int classOf(logic [31:0] w);
    case (w[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      default:    return C_ILL;
    endcase
  endfunction

  // Length of the state path starting at fetch, including a final FIM on halt.
  function automatic int pathLen(int c, bit pcHalt);
    if (pcHalt) return 2;
    case (c)
      C_R, C_I, C_STORE: return 4;
      C_LOAD:            return 5;
      default:           return 3;
    endcase
  endfunction

  function automatic logic [3:0] pathState(int c, bit pcHalt, int i);
    if (i == 0) return 4'd0;
    if (pcHalt) return 4'd9;
    if (i == 1) return 4'd1;
    if (i == 2) begin
      case (c)
        C_R:             return 4'd2;
        C_I:             return 4'd3;
        C_LOAD, C_STORE: return 4'd4;
        C_BRANCH:        return 4'd8;
        default:         return 4'd9;
      endcase
    end
    if (i == 3) begin
      case (c)
        C_LOAD:  return 4'd5;
        C_STORE: return 4'd6;
        default: return 4'd7;
      endcase
    end
    return 4'd7;
  endfunction

  // Strobes follow from where the cycle sits in the instruction's life:
  // the last cycle retires it, cycle 2 is the ALU step, cycle 3 is memory.
  function automatic obs_t expected(logic [31:0] w, logic [31:0] pcv, logic z, int i);
    obs_t e;
    int   c;
    bit   pcHalt;
    bit   halts;
    bit   last;
    bit   taken;
    c      = classOf(w);
    pcHalt = (pcv >= NUM_INSTR);
    halts  = pcHalt || (c == C_ILL);
    last   = !halts && (i == pathLen(c, pcHalt) - 1);
    taken  = ((w[14:12] == 3'd0) && z) || ((w[14:12] == 3'd1) && !z);
    e      = '0;
    e.st   = pathState(c, pcHalt, i);
    e.pcw  = last;
    e.pcf  = last && (c == C_BRANCH) && taken;
    e.regw = last && (c == C_R || c == C_I || c == C_LOAD);
    e.meml = !halts && (c == C_LOAD) && (i == 3);
    e.memw = !halts && (c == C_STORE) && (i == 3);
    e.m2r  = !halts && (c == C_LOAD) && (i == 4);
    e.asrc = !halts && (((c == C_I) && (i == 2)) ||
             (((c == C_LOAD) || (c == C_STORE)) && ((i == 2) || (i == 3))));
    if (!halts && i == 2)
      e.aop = (c == C_R || c == C_I) ? 2'b10 : (c == C_BRANCH) ? 2'b01 : 2'b00;
    e.par  = (e.st == 4'd9);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] exp);
    checks++;
    assert (observed === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, exp);
    end
  endtask

  // Runs one instruction from fetch, checking every cycle against the model.
  task automatic applyStimulus(string tag, logic [31:0] w, logic [31:0] pcv, logic z);
    int n;
    bus.instrucao = w;
    bus.pc        = pcv;
    bus.zero      = z;
    n = pathLen(classOf(w), pcv >= NUM_INSTR);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_c%0d", tag, i), 32'(observe()), 32'(expected(w, pcv, z, i)));
      tick();
    end
  endtask

  task automatic doReset(int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    checkOutput("reset_state", 32'(observe()), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  op;
    logic [31:0] pcv;
    int          c;

    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.instrucao = 32'd0;
    bus.pc        = 32'd0;
    bus.zero      = 1'b0;

    doReset(2);

    applyStimulus("add",     32'h002081B3, 32'd0, 1'b0);
    applyStimulus("lw",      32'h0040A283, 32'd1, 1'b0);
    applyStimulus("sw",      32'h0050A423, 32'd2, 1'b1);
    applyStimulus("beq_z1",  32'h00208463, 32'd3, 1'b1);
    applyStimulus("beq_z0",  32'h00208463, 32'd4, 1'b0);
    applyStimulus("bne_z1",  32'h00209463, 32'd5, 1'b1);
    applyStimulus("bne_z0",  32'h00209463, 32'd6, 1'b0);
    applyStimulus("addi",    32'h00508093, 32'd17, 1'b0);
    checkOutput("back_to_fetch", 32'(bus.estado), 32'd0);

    // All-zero word halts and the halt holds.
    applyStimulus("zero_word", 32'd0, 32'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("fim_hold_%0d", i), 32'(observe()),
                  32'(obs_t'({4'd9, 9'd0, 1'b1})));
      tick();
    end
    doReset(1);

    // PC past end of program memory.
    applyStimulus("pc_end", 32'h002081B3, 32'd18, 1'b0);
    checkOutput("pc_end_hold", 32'({bus.estado, bus.parado}), 32'({4'd9, 1'b1}));
    doReset(1);

    // Reset in the middle of a load.
    bus.instrucao = 32'h0040A283;
    bus.pc        = 32'd0;
    repeat (3) tick();
    checkOutput("in_ler_mem", 32'(bus.estado), 32'd5);
    doReset(1);

`ifdef PERF_CNT_EN
    checkOutput("perf_clear_ciclos", bus.ciclos, 32'd0);
    checkOutput("perf_clear_instr", bus.instr_exec, 32'd0);
    applyStimulus("perf_add", 32'h002081B3, 32'd0, 1'b0);
    applyStimulus("perf_halt", 32'h002081B3, 32'd18, 1'b0);
    repeat (3) tick();
    checkOutput("perf_ciclos", bus.ciclos, 32'd5);
    checkOutput("perf_instr", bus.instr_exec, 32'd1);
    doReset(1);
`endif

    // Randomized instructions of every class.
    for (int k = 0; k < 40; k++) begin
      c  = int'($urandom_range(0, 6));
      case (c)
        C_R:      op = 7'b0110011;
        C_I:      op = 7'b0010011;
        C_LOAD:   op = 7'b0000011;
        C_STORE:  op = 7'b0100011;
        C_BRANCH: op = 7'b1100011;
        default: begin
          op = 7'($urandom);
          if (classOf({25'd0, op}) != C_ILL) op = 7'b1111111;
        end
      endcase
      w   = {$urandom} & 32'hFFFF_FF80;
      w   = w | {25'd0, op};
      pcv = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(18, 1000))
                                        : 32'($urandom_range(0, 17));
      applyStimulus($sformatf("rnd%0d", k), w, pcv, 1'($urandom));
      if (bus.parado === 1'b1) doReset(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Multicycle control FSM for the RISC-V datapath. Drives the 4-bit `estado` bus. The instruction fetch stage latches `instrucao` when `estado == 4'b0000`, and the controller decodes that word in the following cycle. From the opcode it sequences each instruction through its execute, memory and write-back states, and emits the per-state control strobes for PC, register file, ALU and data memory. Stops permanently (halt) on an illegal or all-zero word, or when PC runs past the end of program memory.

Parameters:
NUM_INSTR, 18, number of words in instruction memory; valid PC range is 0..NUM_INSTR-1 (PC is a word index).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instrucao  input  32  instruction word; valid from DECODIFICA onward, stable until next BUSCA
pc  input  32  current PC (word index)
zero  input  1  ALU zero flag, sampled in DESVIO
estado  output  4  current FSM state
pc_escreve  output  1  PC load strobe
pc_fonte  output  1  0 = PC+1, 1 = PC+branch offset
reg_escreve  output  1  register file write enable
mem_le  output  1  data memory read enable
mem_escreve  output  1  data memory write enable
mem_para_reg  output  1  write-back source: 0 = ALU, 1 = memory
alu_src  output  1  ALU B operand: 0 = rs2, 1 = immediate
alu_op  output  2  00 = add, 01 = sub, 10 = decode funct3/funct7
parado  output  1  halted flag

Behaviour:
- Reset: synchronous, active-high; clk is the only clock. On a reset edge: estado=0000, parado=0, all strobes 0, alu_op=00. Reset overrides every state, including FIM and mid-instruction states.
- State register: 4 bits, registered. Outputs are combinational decode of estado. In DESVIO the outputs also depend on zero and instrucao[14:12].
- State encodings:
  - 0000 BUSCA
  - 0001 DECODIFICA
  - 0010 EXEC_R
  - 0011 EXEC_I
  - 0100 CALC_END
  - 0101 LER_MEM
  - 0110 ESCREVE_MEM
  - 0111 ESCRITA_REG
  - 1000 DESVIO
  - 1001 FIM
  - 1010..1111 unused; any of these goes to FIM next cycle.
- BUSCA: all strobes 0. If pc >= NUM_INSTR, next state is FIM; otherwise DECODIFICA.
- DECODIFICA: strobes 0. Next state by opcode instrucao[6:0]:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> CALC_END
  - 1100011 -> DESVIO
  - anything else, including instrucao==0 -> FIM
- EXEC_R: alu_op=10, alu_src=0. Next: ESCRITA_REG.
- EXEC_I: alu_op=10, alu_src=1. Next: ESCRITA_REG.
- CALC_END: alu_op=00, alu_src=1. Next: LER_MEM for a load, ESCREVE_MEM for a store.
- LER_MEM: mem_le=1, alu_op=00, alu_src=1. Next: ESCRITA_REG.
- ESCREVE_MEM: mem_escreve=1, alu_op=00, alu_src=1, pc_escreve=1, pc_fonte=0. Next: BUSCA.
- ESCRITA_REG: reg_escreve=1, pc_escreve=1, pc_fonte=0. mem_para_reg=1 if opcode is load, else 0. Next: BUSCA.
- DESVIO: alu_op=01, alu_src=0, pc_escreve=1.
  - Branch taken when (funct3==000 and zero) or (funct3==001 and !zero); pc_fonte = taken.
  - Any other funct3: not taken, pc_fonte=0.
  - Next: BUSCA.
- FIM: parado=1, all strobes 0. Stays in FIM until reset.
- Cycle counts per instruction: R/I = 4, load = 5, store = 4, branch = 3.
- pc_escreve is high exactly once per completed instruction, in its final state.
- No strobe is ever asserted in BUSCA, DECODIFICA or FIM.

Optional Feature:
Macro PERF_CNT_EN.
- Defined: adds two outputs, ciclos (32 bits) and instr_exec (32 bits).
  - ciclos increments every cycle while estado != FIM.
  - instr_exec increments on every cycle with pc_escreve=1.
  - Both clear on reset and freeze in FIM.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held for 2 cycles then released, pc=0 -> estado=0000, all strobes 0, parado=0; estado=0001 on the next edge.
- instrucao=0x002081B3 (add x3,x1,x2) -> estado sequence 0000,0001,0010,0111,0000; reg_escreve=1 and pc_escreve=1 only in 0111; alu_op=10 in 0010.
- instrucao=0x0040A283 (lw) -> 0000,0001,0100,0101,0111; mem_le=1 in 0101; mem_para_reg=1 in 0111.
- instrucao=0x0050A423 (sw) -> 0000,0001,0100,0110,0000; mem_escreve=1 and pc_escreve=1 in 0110; reg_escreve never 1.
- instrucao=0x00208463 (beq): with zero=1 -> pc_fonte=1 in 1000; with zero=0 -> pc_fonte=0. Same word with funct3=001 (bne) -> inverted results.
- Halt cases: instrucao=0 in DECODIFICA -> FIM, parado=1 held for 10 cycles. pc=18 in BUSCA -> FIM. Reset asserted while in FIM or LER_MEM -> estado=0000, parado=0 on that edge. With PERF_CNT_EN: add then halt -> instr_exec=1, ciclos=5.
